// File: rtl/jtag_defs.sv
// Shared TAP state encodings, IR codes and DTMCS/DMI field constants
// for the oversampled JTAG debug transport module.
package jtag_defs;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_e;

    localparam int IR_W = 5;
    localparam logic [4:0] IR_IDCODE  = 5'h01;
    localparam logic [4:0] IR_DTMCS   = 5'h10;
    localparam logic [4:0] IR_DMI     = 5'h11;
    localparam logic [4:0] IR_BYPASS  = 5'h1f;
    localparam logic [4:0] IR_CAPTURE = 5'b00001;

    localparam logic [2:0] DTMCS_IDLE    = 3'd5;
    localparam logic [3:0] DTMCS_VERSION = 4'd1;

    localparam int DMI_DATA_W = 32;
    localparam int DMI_OP_W   = 2;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_BUSY  = 2'b11;

    function automatic tap_state_e tap_next(input tap_state_e s,
                                            input logic tms);
        tap_state_e n;
        case (s)
            TLR:      n = tms ? TLR      : RTI;
            RTI:      n = tms ? SEL_DR   : RTI;
            SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   n = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: n = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: n = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: n = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: n = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   n = tms ? SEL_DR   : RTI;
            SEL_IR:   n = tms ? TLR      : CAP_IR;
            CAP_IR:   n = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: n = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: n = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: n = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: n = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   n = tms ? SEL_DR   : RTI;
            default:  n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Two-flop synchroniser for one JTAG pin, plus a third flop that
// turns level changes into single-clk rise/fall pulses.
module jtag_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/jtag_dtm_sync.sv
// RISC-V JTAG DTM clocked entirely by clk: TAP FSM, IR/DR scan chains
// and the DMI request/response handshake toward the debug module.
module jtag_dtm_sync
    import jtag_defs::*;
#(
    parameter logic [31:0] IDCODE    = 32'h1E200A6F,
    parameter int          DMI_ABITS = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   jtag_TCK,
    input  logic                   jtag_TMS,
    input  logic                   jtag_TDI,
    output logic                   jtag_TDO,
    output logic                   dtm_req_valid,
    input  logic                   dtm_req_ready,
    output logic [DMI_ABITS+33:0]  dtm_req_data,
    input  logic                   dm_resp_valid,
    input  logic [DMI_ABITS+33:0]  dm_resp_data
);

    localparam int DW = DMI_ABITS + DMI_DATA_W + DMI_OP_W;

    logic tck_rise, tck_fall, tck_lvl;
    logic tms, tms_rise, tms_fall;
    logic tdi, tdi_rise, tdi_fall;

    jtag_sync_edge u_tck (
        .clk   (clk),
        .rst_n (rst),
        .d     (jtag_TCK),
        .level (tck_lvl),
        .rise  (tck_rise),
        .fall  (tck_fall)
    );

    jtag_sync_edge u_tms (
        .clk   (clk),
        .rst_n (rst),
        .d     (jtag_TMS),
        .level (tms),
        .rise  (tms_rise),
        .fall  (tms_fall)
    );

    jtag_sync_edge u_tdi (
        .clk   (clk),
        .rst_n (rst),
        .d     (jtag_TDI),
        .level (tdi),
        .rise  (tdi_rise),
        .fall  (tdi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{tck_lvl, tms_rise, tms_fall,
                           tdi_rise, tdi_fall, dm_resp_data[1:0]};

    tap_state_e    state;
    logic [4:0]    ir;
    logic [DW-1:0] sr;
    logic [DW-3:0] resp_reg;
    logic          busy;

    logic          ir_idcode, ir_dtmcs, ir_dmi;
    logic [5:0]    sel_w;
    logic [DW-1:0] cap_dr;
    logic [1:0]    dmistat;
    logic [31:0]   dtmcs;
    logic          shifting;

    assign ir_idcode = (ir == IR_IDCODE);
    assign ir_dtmcs  = (ir == IR_DTMCS);
    assign ir_dmi    = (ir == IR_DMI);
    assign shifting  = (state == SHIFT_IR) || (state == SHIFT_DR);
    assign dmistat   = busy ? 2'b11 : 2'b00;
    assign dtmcs     = {14'b0, 1'b0, 1'b0, 1'b0, DTMCS_IDLE, dmistat,
                        6'(DMI_ABITS), DTMCS_VERSION};

    always_comb begin
        sel_w = 6'd1;
        if (state == SHIFT_IR) begin
            sel_w = 6'(IR_W);
        end else begin
            unique case (1'b1)
                ir_idcode, ir_dtmcs: sel_w = 6'd32;
                ir_dmi:              sel_w = 6'(DW);
                default:             sel_w = 6'd1;
            endcase
        end
    end

    // Unrecognised IR codes fall through to BYPASS, which captures 0.
    always_comb begin
        cap_dr = '0;
        unique case (1'b1)
            ir_idcode: cap_dr = DW'(IDCODE);
            ir_dtmcs:  cap_dr = DW'(dtmcs);
            ir_dmi:    cap_dr = {resp_reg, dmistat};
            default:   cap_dr = '0;
        endcase
    end

    function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] v,
                                               input logic b,
                                               input logic [5:0] w);
        logic [DW-1:0] r;
        r = v >> 1;
        r[w - 6'd1] = b;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= TLR;
            ir            <= IR_IDCODE;
            sr            <= '0;
            resp_reg      <= '0;
            busy          <= 1'b0;
            jtag_TDO      <= 1'b0;
            dtm_req_valid <= 1'b0;
            dtm_req_data  <= '0;
        end else begin
            if (dm_resp_valid)
                resp_reg <= dm_resp_data[DW-1:2];
            if (dtm_req_valid && dtm_req_ready)
                dtm_req_valid <= 1'b0;
            if (state == TLR)
                ir <= IR_IDCODE;
            if (tck_fall)
                jtag_TDO <= shifting ? sr[0] : 1'b0;
            if (tck_rise) begin
                state <= tap_next(state, tms);
                unique case (state)
                    CAP_IR:   sr <= DW'(IR_CAPTURE);
                    CAP_DR:   sr <= cap_dr;
                    SHIFT_IR,
                    SHIFT_DR: sr <= shift_in(sr, tdi, sel_w);
                    UPD_IR:   ir <= sr[IR_W-1:0];
                    UPD_DR: begin
                        if (ir_dmi) begin
                            // A scan landing on an unfinished request is lost.
                            if (dtm_req_valid) begin
                                busy <= 1'b1;
                            end else if (sr[1:0] == OP_READ ||
                                         sr[1:0] == OP_WRITE) begin
                                dtm_req_valid <= 1'b1;
                                dtm_req_data  <= sr;
                            end
                        end else if (ir_dtmcs) begin
                            if (sr[16] || sr[17])
                                busy <= 1'b0;
                            if (sr[17])
                                dtm_req_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/jtag_dtm_sync.md
JTAG_DTM_SYNC -- requirements
Module: jtag_dtm_sync

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1E200A6F, value loaded into the IDCODE DR at Capture-DR.
REQ-002 SHALL have parameter DMI_ABITS, default 6, DMI address width; the DMI DR width is DMI_ABITS+34 (40 by default).
REQ-003 SHALL have port clk, input, 1, the single system clock; all state is sampled on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port jtag_TCK, input, 1, asynchronous JTAG test clock, oversampled.
REQ-006 SHALL have port jtag_TMS, input, 1, test mode select.
REQ-007 SHALL have port jtag_TDI, input, 1, test data in.
REQ-008 SHALL have port jtag_TDO, output, 1, test data out.
REQ-009 SHALL have port dtm_req_valid, output, 1, DMI request pending to the debug module.
REQ-010 SHALL have port dtm_req_ready, input, 1, the debug module accepts the request.
REQ-011 SHALL have port dtm_req_data, output, 40, {addr[39:34], data[33:2], op[1:0]}.
REQ-012 SHALL have port dm_resp_valid, input, 1, a response word is present.
REQ-013 SHALL have port dm_resp_data, input, 40, the response word in the same layout as REQ-011.

Function
REQ-014 TCK, TMS and TDI SHALL pass two flops each, then a third TCK flop; tck_rise/tck_fall are one-clk pulses, 3 clk after the pin edge; clk SHALL be at least 4x TCK.
REQ-015 A 16-state IEEE 1149.1 TAP FSM SHALL advance only on tck_rise, using the synced TMS.
REQ-016 Five consecutive tck_rise with TMS=1 SHALL reach Test-Logic-Reset from any state; Test-Logic-Reset SHALL load IR=5'h01.
REQ-017 The IR SHALL be 5 bits: 5'h01 IDCODE, 5'h10 DTMCS, 5'h11 DMI, 5'h1f BYPASS; any other code SHALL select BYPASS.
REQ-018 Capture-IR SHALL load 5'b00001 into the IR shift register.
REQ-019 Shift-IR/Shift-DR SHALL shift LSB-first on tck_rise, with TDI entering at bit width-1 of the selected register (IR 5, IDCODE/DTMCS 32, DMI 40, BYPASS 1).
REQ-020 Capture-DR SHALL load, by IR: IDCODE; DTMCS = {14'b0, 1'b0, 1'b0, 1'b0, 3'd5, dmistat, 6'd6, 4'd1}; DMI = {resp_reg[39:2], busy ? 2'b11 : 2'b00}; BYPASS = 0.
REQ-021 resp_reg SHALL latch dm_resp_data on any clk with dm_resp_valid=1, and reset to 0.
REQ-022 jtag_TDO SHALL update on tck_fall to the shift-register LSB while in Shift-IR/Shift-DR, and be 0 otherwise.
REQ-023 Update-IR SHALL copy the IR shift register to IR.
REQ-024 Update-DR with IR=DMI and op in {01,10}, with no request pending, SHALL on the next clk set dtm_req_valid=1 and dtm_req_data=DMI shift register.
REQ-025 Update-DR with IR=DMI while dtm_req_valid=1 SHALL discard the request and set sticky busy (dmistat=2'b11).
REQ-026 dtm_req_valid and dtm_req_data SHALL hold stable until a clk with dtm_req_ready=1, and valid SHALL clear on that edge.
REQ-027 Update-DR with IR=DTMCS: bit16=1 (dmireset) SHALL clear busy; bit17=1 (dmihardreset) SHALL clear busy and dtm_req_valid.
REQ-028 op=00 or 11 at Update-DR SHALL issue no request.

Reset
REQ-029 While rst=0, the block SHALL hold: TAP in Test-Logic-Reset, IR=5'h01, all shift/sync flops 0, jtag_TDO=0, dtm_req_valid=0, dtm_req_data=0, busy=0, resp_reg=0.
REQ-030 Reset asserted mid-scan or mid-handshake SHALL abandon the operation with no request issued after release.

Structure
REQ-031 Package jtag_defs SHALL hold TAP state encodings, IR codes, DTMCS constant fields and DMI widths.
REQ-032 Sub-module jtag_sync_edge (2-FF synchroniser plus edge detect) SHALL be instantiated per input pin; the TAP FSM, registers and DMI handshake SHALL live in jtag_dtm_sync.

Verification
REQ-033 8 TCK with TMS=1 -> TAP=Test-Logic-Reset, IR=5'h01; then IDCODE DR scan -> TDO returns 32'h1E200A6F LSB-first.
REQ-034 IR scan shifting 5'h11 -> TDO returns 5'b00001, IR=5'h11 after Update-IR.
REQ-035 DMI scan of {6'h10, 32'h0, 2'b10} with dtm_req_ready=0 -> dtm_req_valid=1, dtm_req_data=40'h4000000002 held; ready=1 for one clk -> valid=0 the next clk.
REQ-036 Second DMI write while valid=1 -> no new request, next DMI capture op=2'b11; DTMCS write with bit16=1 -> next capture op=2'b00.
REQ-037 dm_resp_data=40'h44DEADBEEC pulsed, then DMI read scan -> shifted-out bits [33:2]=32'h37AB6FBB, op=2'b00.
REQ-038 rst=0 asserted mid Shift-DR -> all outputs 0 and IR=5'h01; after release, no dtm_req_valid without a new complete scan.
